// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV32I pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {IDLE, WAIT} hz_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// E-stage operand forward select for one source register; M beats W.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rdM,
    input  logic [4:0] rdW,
    input  logic       reg_writeM,
    input  logic       reg_writeW,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (rs != 5'd0 && rs == rdM && reg_writeM)
            fwd = FWD_MEM;
        else if (rs != 5'd0 && rs == rdW && reg_writeW)
            fwd = FWD_WB;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control for the 5-stage core, including the data
// memory wait-state FSM with timeout and a saturating stall counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic [4:0]       rdM,
    input  logic [4:0]       rdW,
    input  logic             reg_writeM,
    input  logic             reg_writeW,
    input  logic             loadE,
    input  logic             pc_srcE,
    input  logic             mem_reqM,
    input  logic             mem_ack,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    hz_state_t       state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
    logic            err_nxt;
    logic            timeout, mem_stall, lw_stall;
    logic [1:0]      fwd_a, fwd_b;

    fwd_sel u_fwd_a (
        .rs(rs1E), .rdM(rdM), .rdW(rdW),
        .reg_writeM(reg_writeM), .reg_writeW(reg_writeW), .fwd(fwd_a)
    );

    fwd_sel u_fwd_b (
        .rs(rs2E), .rdM(rdM), .rdW(rdW),
        .reg_writeM(reg_writeM), .reg_writeW(reg_writeW), .fwd(fwd_b)
    );

    // All controls are forced quiet while reset is held.
    assign timeout   = (state == WAIT) && (wait_cnt == WC_LAST);
    assign mem_stall = rst && mem_reqM && !mem_ack && !timeout;
    assign lw_stall  = rst && loadE && (rdE != 5'd0) && (rdE == rs1D || rdE == rs2D);

    assign stallF    = mem_stall || lw_stall;
    assign stallD    = mem_stall || lw_stall;
    assign stallE    = mem_stall;
    assign stallM    = mem_stall;
    assign flushW    = mem_stall;
    assign flushD    = rst && pc_srcE && !mem_stall;
    assign flushE    = rst && (lw_stall || pc_srcE) && !mem_stall;
    assign forwardAE = rst ? fwd_a : FWD_RF;
    assign forwardBE = rst ? fwd_b : FWD_RF;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        err_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (mem_reqM && !mem_ack) begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = WC_W'(1);
                end
            end
            WAIT: begin
                if (!mem_reqM || mem_ack) begin
                    state_nxt    = IDLE;
                    wait_cnt_nxt = '0;
                end else if (timeout) begin
                    // Access abandoned: pipeline moves on, error reported next cycle.
                    state_nxt    = IDLE;
                    wait_cnt_nxt = '0;
                    err_nxt      = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + WC_W'(1);
                end
            end
            default: begin
                state_nxt    = IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            mem_err  <= err_nxt;
            if (mem_stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
